draw_projectile_dog: RTL

- Downstream consumer of the dog power-bar stage.
- Captures throw_force when the player releases space and flies a projectile leftward, one motion update per video frame, under gravity.
- Overlays the projectile square on the VGA stream and reports its position and landing to game logic.
- Sits directly after the power-bar stage in the vga_if chain.

---
 rtl/draw_projectile_dog_if.sv | 18 +
 rtl/draw_projectile_dog.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/draw_projectile_dog_if.sv
// VGA stream bundle shared by the draw stages of the dog chain.
// Carries pixel counters, sync/blank strobes and the 12-bit colour.
interface vga_if;
   logic [10:0] hcount;
   logic [10:0] vcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;
   logic [11:0] rgb;

   modport vga_in (
      input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );
   modport vga_out (
      output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
   );
endinterface

// File: rtl/draw_projectile_dog.sv
// Thrown-dog projectile: launch on space release, per-frame ballistic motion, overlay.
// Optional PROJ_WIND_EN adds a signed wind input that nudges vx every frame.
module draw_projectile_dog #(
   parameter int          START_X   = 876,
   parameter int          START_Y   = 380,
   parameter int          GROUND_Y  = 600,
   parameter int          GRAVITY   = 1,
   parameter int          PROJ_SIZE = 8,
   parameter logic [11:0] PROJ_RGB  = 12'h840,
   parameter int          LAND_HOLD = 60
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               space,
   input  logic [9:0]         throw_force,
`ifdef PROJ_WIND_EN
   input  logic signed [3:0]  wind,
`endif
   output logic signed [11:0] proj_x,
   output logic signed [11:0] proj_y,
   output logic               busy,
   output logic               landed,
   vga_if.vga_in              vga_in,
   vga_if.vga_out             vga_out
);

   typedef enum logic [1:0] {IDLE, LAUNCH, FLYING, LANDED} state_t;

   localparam logic signed [11:0] SX  = 12'(START_X);
   localparam logic signed [11:0] SY  = 12'(START_Y);
   localparam logic signed [11:0] GND = 12'(GROUND_Y);
   localparam logic signed [11:0] GRV = 12'(GRAVITY);
   localparam logic signed [12:0] SZ  = 13'(PROJ_SIZE);
   localparam logic [11:0]        HLD = 12'(LAND_HOLD);

   state_t             state, state_nxt;
   logic [7:0]         vx, vx_nxt;
   logic signed [11:0] vy, vy_nxt;
   logic signed [11:0] x_nxt, y_nxt;
   logic signed [11:0] x_n, y_n;
   logic [11:0]        cnt, cnt_nxt;
   logic               landed_nxt;
   logic               space_prev, vblnk_prev;
   logic               release_det, tick;
`ifdef PROJ_WIND_EN
   logic signed [3:0]  wind_r, wind_nxt;
   logic signed [9:0]  vx_sum;
`endif

   assign release_det = space_prev && !space;
   assign tick        = !vblnk_prev && vga_in.vblnk;
   assign x_n         = proj_x - $signed({4'b0000, vx});
   assign y_n         = proj_y - vy;
   assign busy        = (state != IDLE);

`ifdef PROJ_WIND_EN
   assign vx_sum = $signed({2'b00, vx}) + {{6{wind_r[3]}}, wind_r};
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         proj_x     <= SX;
         proj_y     <= SY;
         vx         <= '0;
         vy         <= '0;
         cnt        <= '0;
         landed     <= 1'b0;
         space_prev <= 1'b0;
         vblnk_prev <= 1'b0;
`ifdef PROJ_WIND_EN
         wind_r     <= '0;
`endif
      end else begin
         state      <= state_nxt;
         proj_x     <= x_nxt;
         proj_y     <= y_nxt;
         vx         <= vx_nxt;
         vy         <= vy_nxt;
         cnt        <= cnt_nxt;
         landed     <= landed_nxt;
         space_prev <= space;
         vblnk_prev <= vga_in.vblnk;
`ifdef PROJ_WIND_EN
         wind_r     <= wind_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt  = state;
      x_nxt      = proj_x;
      y_nxt      = proj_y;
      vx_nxt     = vx;
      vy_nxt     = vy;
      cnt_nxt    = cnt;
      landed_nxt = 1'b0;
`ifdef PROJ_WIND_EN
      wind_nxt   = wind_r;
`endif
      unique case (state)
         IDLE: begin
            if (release_det) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            // force is stable only one cycle after the release edge
            vx_nxt    = throw_force[9:2];
            vy_nxt    = {5'b00000, throw_force[9:3]};
            x_nxt     = SX;
            y_nxt     = SY;
            state_nxt = FLYING;
`ifdef PROJ_WIND_EN
            wind_nxt  = wind;
`endif
         end
         FLYING: begin
            if (tick) begin
               vy_nxt = vy - GRV;
`ifdef PROJ_WIND_EN
               if (vx_sum < 0)           vx_nxt = 8'd0;
               else if (vx_sum > 10'sd255) vx_nxt = 8'd255;
               else                      vx_nxt = vx_sum[7:0];
`endif
               if (y_n >= GND) begin
                  y_nxt      = GND;
                  x_nxt      = (x_n < 0) ? 12'sd0 : x_n;
                  landed_nxt = 1'b1;
                  state_nxt  = LANDED;
               end else if (x_n < 0) begin
                  x_nxt      = 12'sd0;
                  y_nxt      = y_n;
                  landed_nxt = 1'b1;
                  state_nxt  = LANDED;
               end else begin
                  x_nxt = x_n;
                  y_nxt = y_n;
               end
            end
         end
         LANDED: begin
            if (tick) begin
               if (cnt + 12'd1 >= HLD) begin
                  cnt_nxt   = '0;
                  x_nxt     = SX;
                  y_nxt     = SY;
                  state_nxt = IDLE;
               end else begin
                  cnt_nxt = cnt + 12'd1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // 13-bit signed compare keeps off-screen positions from wrapping
   logic signed [12:0] hc, vc, px, py;
   logic               in_box;

   assign hc     = $signed({2'b00, vga_in.hcount});
   assign vc     = $signed({2'b00, vga_in.vcount});
   assign px     = {proj_x[11], proj_x};
   assign py     = {proj_y[11], proj_y};
   assign in_box = (state == FLYING || state == LANDED)
                && hc >= px && hc < px + SZ
                && vc >= py && vc < py + SZ;

   assign vga_out.hcount = vga_in.hcount;
   assign vga_out.vcount = vga_in.vcount;
   assign vga_out.hsync  = vga_in.hsync;
   assign vga_out.vsync  = vga_in.vsync;
   assign vga_out.hblnk  = vga_in.hblnk;
   assign vga_out.vblnk  = vga_in.vblnk;
   assign vga_out.rgb    = in_box ? PROJ_RGB : vga_in.rgb;

endmodule
